// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state encoding, default bus widths and
// the two-way round-robin pick used by APB masters in this codebase.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;
   localparam int APB_CNT_W  = 8;

   // With both requesting, the index not granted last wins; otherwise the lone requester.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      if (req == 2'b11) begin
         return ~last;
      end
      return req[1];
   endfunction

endpackage

// File: rtl/apb_arb_master_if.sv
// APB bus bundle between the arbitrating master and a single APB slave.
interface apb_arb_master_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
);

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is issued.
module apb_rr_arb
   import apb_pkg::*;
(
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic       o_gnt_vld,
   output logic       o_gnt_idx
);

   logic r_last;

   assign o_gnt_vld = i_en & (|i_req);
   assign o_gnt_idx = rr_pick(i_req, r_last);

   // Pointer starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_last <= 1'b1;
      end else if (o_gnt_vld) begin
         r_last <= o_gnt_idx;
      end
   end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin grant, registered SETUP/ACCESS sequencing,
// wait-state timeout, and a one-cycle response pulse to the granted requester.
module apb_arb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,

   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              resp0_valid,
   output logic [DATA_W-1:0] resp0_rdata,
   output logic              resp0_err,

   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              resp1_valid,
   output logic [DATA_W-1:0] resp1_rdata,
   output logic              resp1_err,

   apb_arb_master_if.master  apb
);

   localparam logic [APB_CNT_W-1:0] WAIT_LAST = APB_CNT_W'(TIMEOUT - 1);

   apb_state_e            r_state, w_state_next;
   logic                  r_psel, w_psel_next;
   logic                  r_penable, w_penable_next;
   logic                  r_pwrite, w_pwrite_next;
   logic [ADDR_W-1:0]     r_paddr, w_paddr_next;
   logic [DATA_W-1:0]     r_pwdata, w_pwdata_next;
   logic                  r_owner, w_owner_next;
   logic [APB_CNT_W-1:0]  r_wait_cnt, w_wait_cnt_next;
   logic [1:0]            r_resp_valid, w_resp_valid_next;
   logic                  r_resp_err, w_resp_err_next;
   logic [DATA_W-1:0]     r_resp_rdata, w_resp_rdata_next;

   logic [1:0]            w_req_valid;
   logic [1:0]            w_req_write;
   logic [ADDR_W-1:0]     w_req_addr  [2];
   logic [DATA_W-1:0]     w_req_wdata [2];

   logic                  w_in_access;
   logic                  w_timeout;
   logic                  w_done;
   logic                  w_grant_en;
   logic                  w_gnt_vld;
   logic                  w_gnt_idx;

   assign w_req_valid    = {req1_valid, req0_valid};
   assign w_req_write    = {req1_write, req0_write};
   assign w_req_addr[0]  = req0_addr;
   assign w_req_addr[1]  = req1_addr;
   assign w_req_wdata[0] = req0_wdata;
   assign w_req_wdata[1] = req1_wdata;

   // PREADY on the last allowed wait cycle still completes normally.
   assign w_in_access = (r_state == ACCESS);
   assign w_timeout   = w_in_access & ~apb.PREADY & (r_wait_cnt == WAIT_LAST);
   assign w_done      = w_in_access & (apb.PREADY | w_timeout);
   assign w_grant_en  = PRESETn & ((r_state == IDLE) | w_done);

   apb_rr_arb u_arb (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .i_en      (w_grant_en),
      .i_req     (w_req_valid),
      .o_gnt_vld (w_gnt_vld),
      .o_gnt_idx (w_gnt_idx)
   );

   always_comb begin
      w_state_next      = r_state;
      w_psel_next       = r_psel;
      w_penable_next    = r_penable;
      w_pwrite_next     = r_pwrite;
      w_paddr_next      = r_paddr;
      w_pwdata_next     = r_pwdata;
      w_owner_next      = r_owner;
      w_wait_cnt_next   = r_wait_cnt;
      w_resp_valid_next = 2'b00;
      w_resp_err_next   = 1'b0;
      w_resp_rdata_next = '0;

      case (r_state)
         IDLE: begin
            w_psel_next    = 1'b0;
            w_penable_next = 1'b0;
         end
         SETUP: begin
            w_state_next   = ACCESS;
            w_penable_next = 1'b1;
         end
         ACCESS: begin
            if (w_done) begin
               w_resp_valid_next[r_owner] = 1'b1;
               w_resp_err_next            = w_timeout | apb.PSLVERR;
               if (!w_timeout && !apb.PSLVERR && !r_pwrite) begin
                  w_resp_rdata_next = apb.PRDATA;
               end
               w_state_next   = IDLE;
               w_psel_next    = 1'b0;
               w_penable_next = 1'b0;
            end else begin
               w_wait_cnt_next = r_wait_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next   = IDLE;
            w_psel_next    = 1'b0;
            w_penable_next = 1'b0;
         end
      endcase

      // A grant (from IDLE or on completion) overrides the return to IDLE.
      if (w_gnt_vld) begin
         w_state_next    = SETUP;
         w_psel_next     = 1'b1;
         w_penable_next  = 1'b0;
         w_pwrite_next   = w_req_write[w_gnt_idx];
         w_paddr_next    = w_req_addr[w_gnt_idx];
         w_pwdata_next   = w_req_wdata[w_gnt_idx];
         w_owner_next    = w_gnt_idx;
         w_wait_cnt_next = '0;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state      <= IDLE;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_pwrite     <= 1'b0;
         r_paddr      <= '0;
         r_pwdata     <= '0;
         r_owner      <= 1'b0;
         r_wait_cnt   <= '0;
         r_resp_valid <= 2'b00;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_state      <= w_state_next;
         r_psel       <= w_psel_next;
         r_penable    <= w_penable_next;
         r_pwrite     <= w_pwrite_next;
         r_paddr      <= w_paddr_next;
         r_pwdata     <= w_pwdata_next;
         r_owner      <= w_owner_next;
         r_wait_cnt   <= w_wait_cnt_next;
         r_resp_valid <= w_resp_valid_next;
         r_resp_err   <= w_resp_err_next;
         r_resp_rdata <= w_resp_rdata_next;
      end
   end

   assign apb.PSEL    = r_psel;
   assign apb.PENABLE = r_penable;
   assign apb.PWRITE  = r_pwrite;
   assign apb.PADDR   = r_paddr;
   assign apb.PWDATA  = r_pwdata;

   assign req0_ready  = w_gnt_vld & ~w_gnt_idx;
   assign req1_ready  = w_gnt_vld &  w_gnt_idx;

   // Response registers are shared; each requester only sees them during its own pulse.
   assign resp0_valid = r_resp_valid[0];
   assign resp0_err   = r_resp_valid[0] & r_resp_err;
   assign resp0_rdata = r_resp_valid[0] ? r_resp_rdata : '0;
   assign resp1_valid = r_resp_valid[1];
   assign resp1_err   = r_resp_valid[1] & r_resp_err;
   assign resp1_rdata = r_resp_valid[1] ? r_resp_rdata : '0;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: single transfers, wait states, errors, timeout,
// back-to-back round-robin and mid-transfer reset, checked with immediate assertions.
module tb_apb_arb_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          PCLK;
   logic          PRESETn;
   logic          req0_valid, req0_write, req0_ready, resp0_valid, resp0_err;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, resp0_rdata;
   logic          req1_valid, req1_write, req1_ready, resp1_valid, resp1_err;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, resp1_rdata;

   int checks   = 0;
   int failures = 0;

   apb_arb_master_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

   apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .req0_valid  (req0_valid),
      .req0_write  (req0_write),
      .req0_addr   (req0_addr),
      .req0_wdata  (req0_wdata),
      .req0_ready  (req0_ready),
      .resp0_valid (resp0_valid),
      .resp0_rdata (resp0_rdata),
      .resp0_err   (resp0_err),
      .req1_valid  (req1_valid),
      .req1_write  (req1_write),
      .req1_addr   (req1_addr),
      .req1_wdata  (req1_wdata),
      .req1_ready  (req1_ready),
      .resp1_valid (resp1_valid),
      .resp1_rdata (resp1_rdata),
      .resp1_err   (resp1_err),
      .apb         (apb)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic cyc();
      @(negedge PCLK);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int idx, input logic v, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
      if (idx == 0) begin
         req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
      end
   endtask

   // One transfer from a single requester; finish=0 leaves PREADY low to force a timeout.
   task automatic xfer(input string tag, input int idx, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input bit finish, input logic slverr,
                       input logic [31:0] prdata, input logic exp_err,
                       input logic [31:0] exp_rdata, input int exp_psel);
      int psel_cycles;
      psel_cycles = 0;
      cyc();
      set_req(idx, 1'b1, wr, addr, wdata);
      settle();
      chk({tag, "_ready"}, 64'(idx == 0 ? req0_ready : req1_ready), 64'd1);
      chk({tag, "_other_ready"}, 64'(idx == 0 ? req1_ready : req0_ready), 64'd0);
      cyc();
      set_req(idx, 1'b0, 1'b0, 32'h0, 32'h0);
      apb.PREADY = 1'b1; apb.PSLVERR = 1'b1; apb.PRDATA = 32'hFFFF_FFFF;
      settle();
      if (apb.PSEL) psel_cycles++;
      chk({tag, "_setup_psel"}, 64'(apb.PSEL), 64'd1);
      chk({tag, "_setup_penable"}, 64'(apb.PENABLE), 64'd0);
      chk({tag, "_paddr"}, 64'(apb.PADDR), 64'(addr));
      chk({tag, "_pwrite"}, 64'(apb.PWRITE), 64'(wr));
      if (wr) chk({tag, "_pwdata"}, 64'(apb.PWDATA), 64'(wdata));
      for (int a = 0; a < 40; a++) begin
         cyc();
         apb.PREADY  = finish && (a == waits);
         apb.PSLVERR = slverr;
         apb.PRDATA  = prdata;
         settle();
         if (apb.PSEL) psel_cycles++;
         chk({tag, "_access_penable"}, 64'(apb.PENABLE), 64'd1);
         if (apb.PREADY) break;
         if (!finish && a == TO - 1) break;
      end
      cyc();
      apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA = 32'h0;
      settle();
      chk({tag, "_resp_valid"}, 64'(idx == 0 ? resp0_valid : resp1_valid), 64'd1);
      chk({tag, "_other_resp"}, 64'(idx == 0 ? resp1_valid : resp0_valid), 64'd0);
      chk({tag, "_resp_err"}, 64'(idx == 0 ? resp0_err : resp1_err), 64'(exp_err));
      chk({tag, "_resp_rdata"}, 64'(idx == 0 ? resp0_rdata : resp1_rdata), 64'(exp_rdata));
      chk({tag, "_psel_after"}, 64'(apb.PSEL), 64'd0);
      chk({tag, "_psel_cycles"}, 64'(psel_cycles), 64'(exp_psel));
      $display("xfer %s req%0d wr=%0b addr=%h err=%0b rdata=%h psel_cycles=%0d",
               tag, idx, wr, addr, idx == 0 ? resp0_err : resp1_err,
               idx == 0 ? resp0_rdata : resp1_rdata, psel_cycles);
      cyc();
      settle();
      chk({tag, "_resp_pulse_end"}, 64'(idx == 0 ? resp0_valid : resp1_valid), 64'd0);
   endtask

   initial begin
      int gnt_seq [6];
      int ngnt;
      int nresp;
      int stray;
      bit both_seen;

      PRESETn = 1'b0;
      set_req(0, 1'b1, 1'b1, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA = 32'h0;

      // Reset state, with req0_valid held to show ready stays low under reset.
      repeat (3) cyc();
      settle();
      chk("rst_psel", 64'(apb.PSEL), 64'd0);
      chk("rst_penable", 64'(apb.PENABLE), 64'd0);
      chk("rst_pwrite", 64'(apb.PWRITE), 64'd0);
      chk("rst_paddr", 64'(apb.PADDR), 64'd0);
      chk("rst_pwdata", 64'(apb.PWDATA), 64'd0);
      chk("rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("rst_resp", 64'({resp0_valid, resp1_valid, resp0_err, resp1_err}), 64'd0);
      chk("rst_rdata", 64'({resp0_rdata, resp1_rdata}), 64'd0);
      cyc();
      req0_valid = 1'b0;
      PRESETn = 1'b1;

      // Write, PREADY on first ACCESS cycle.
      xfer("wr_fast", 0, 1'b1, 32'h4, 32'hDEADBEEF, 0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2);

      // Fresh reset so the first tie goes to requester 0.
      cyc(); PRESETn = 1'b0;
      cyc(); PRESETn = 1'b1;

      // Simultaneous reads: req0 first, req1 back-to-back.
      cyc();
      set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h20, 32'h0);
      settle();
      chk("b2b_req0_ready", 64'(req0_ready), 64'd1);
      chk("b2b_req1_wait", 64'(req1_ready), 64'd0);
      cyc();
      req0_valid = 1'b0;
      settle();
      chk("b2b_setup0_paddr", 64'(apb.PADDR), 64'h10);
      chk("b2b_setup_no_grant", 64'(req1_ready), 64'd0);
      cyc();
      apb.PREADY = 1'b1; apb.PRDATA = 32'h11;
      settle();
      chk("b2b_access0_penable", 64'(apb.PENABLE), 64'd1);
      chk("b2b_req1_ready", 64'(req1_ready), 64'd1);
      cyc();
      req1_valid = 1'b0;
      apb.PREADY = 1'b0; apb.PRDATA = 32'h0;
      settle();
      chk("b2b_resp0_valid", 64'(resp0_valid), 64'd1);
      chk("b2b_resp0_rdata", 64'(resp0_rdata), 64'h11);
      chk("b2b_no_idle_psel", 64'(apb.PSEL), 64'd1);
      chk("b2b_setup1_penable", 64'(apb.PENABLE), 64'd0);
      chk("b2b_setup1_paddr", 64'(apb.PADDR), 64'h20);
      cyc();
      apb.PREADY = 1'b1; apb.PRDATA = 32'h22;
      settle();
      chk("b2b_access1_penable", 64'(apb.PENABLE), 64'd1);
      cyc();
      apb.PREADY = 1'b0; apb.PRDATA = 32'h0;
      settle();
      chk("b2b_resp1_valid", 64'(resp1_valid), 64'd1);
      chk("b2b_resp1_rdata", 64'(resp1_rdata), 64'h22);
      chk("b2b_resp1_err", 64'(resp1_err), 64'd0);
      chk("b2b_resp0_quiet", 64'(resp0_valid), 64'd0);
      $display("xfer b2b req0 rdata=11 then req1 rdata=%h", resp1_rdata);

      // Three wait states then PSLVERR on the last allowed wait cycle.
      xfer("rd_slverr", 1, 1'b0, 32'h30, 32'h0, 3, 1'b1, 1'b1, 32'h55, 1'b1, 32'h0, 5);
      // Same boundary without error completes normally with data.
      xfer("rd_edge_ok", 0, 1'b0, 32'h40, 32'h0, 3, 1'b1, 1'b0, 32'h77, 1'b0, 32'h77, 5);
      // PREADY never comes: abort after TIMEOUT ACCESS cycles.
      xfer("rd_timeout", 1, 1'b0, 32'h50, 32'h0, 0, 1'b0, 1'b0, 32'hAB, 1'b1, 32'h0, 5);

      // Both requesters continuously valid: grants alternate starting with 0.
      ngnt = 0; nresp = 0; both_seen = 1'b0;
      for (int c = 0; c < 40 && ngnt < 6; c++) begin
         cyc();
         if (c == 0) begin
            set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
            set_req(1, 1'b1, 1'b1, 32'h200, 32'hCAFE);
            apb.PREADY = 1'b1; apb.PRDATA = 32'h5A;
         end
         settle();
         if (req0_ready && req1_ready) both_seen = 1'b1;
         if (resp0_valid && resp1_valid) both_seen = 1'b1;
         if (req0_ready) gnt_seq[ngnt++] = 0;
         else if (req1_ready) gnt_seq[ngnt++] = 1;
         nresp += int'(resp0_valid) + int'(resp1_valid);
      end
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      settle();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) begin cyc(); settle(); end
         if (req0_ready || req1_ready) both_seen = 1'b1;
         if (resp0_valid && resp1_valid) both_seen = 1'b1;
         nresp += int'(resp0_valid) + int'(resp1_valid);
      end
      apb.PREADY = 1'b0; apb.PRDATA = 32'h0;
      chk("rr_grant_count", 64'(ngnt), 64'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < ngnt) chk($sformatf("rr_grant_%0d", k), 64'(gnt_seq[k]), 64'(k % 2));
      end
      chk("rr_exclusive", 64'(both_seen), 64'd0);
      chk("rr_resp_count", 64'(nresp), 64'd6);
      $display("xfer rr grants=%0d responses=%0d", ngnt, nresp);

      // Reset during ACCESS abandons the transfer silently.
      cyc();
      set_req(0, 1'b1, 1'b1, 32'h300, 32'h1234);
      settle();
      cyc();
      req0_valid = 1'b0;
      settle();
      cyc();
      settle();
      chk("mid_rst_in_access", 64'(apb.PENABLE), 64'd1);
      cyc();
      set_req(1, 1'b1, 1'b0, 32'h400, 32'h0);
      PRESETn = 1'b0;
      settle();
      chk("mid_rst_psel", 64'(apb.PSEL), 64'd0);
      chk("mid_rst_penable", 64'(apb.PENABLE), 64'd0);
      chk("mid_rst_pwrite", 64'(apb.PWRITE), 64'd0);
      chk("mid_rst_paddr", 64'(apb.PADDR), 64'd0);
      chk("mid_rst_pwdata", 64'(apb.PWDATA), 64'd0);
      chk("mid_rst_req1_ready", 64'(req1_ready), 64'd0);
      cyc();
      req1_valid = 1'b0;
      PRESETn = 1'b1;
      apb.PREADY = 1'b1;
      stray = 0;
      for (int c = 0; c < 5; c++) begin
         settle();
         if (resp0_valid || resp1_valid || apb.PSEL) stray++;
         cyc();
      end
      apb.PREADY = 1'b0;
      chk("mid_rst_no_resp", 64'(stray), 64'd0);
      $display("xfer mid_reset abandoned stray_events=%0d", stray);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
